// File: rtl/lint_slave_mem_if.sv
// LINT / XBAR_TCDM request-response bundle shared by an initiator and a responder.
// The master drives the request fields; the slave drives grant and the registered response.
interface lint_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req;
    logic [ADDR_WIDTH-1:0]     add;
    logic                      wen;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   be;
    logic                      gnt;
    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_opc;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata, r_opc
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata, r_opc
    );
endinterface

// File: rtl/lint_slave_mem.sv
// LINT responder backed by a word-addressed, byte-enabled scratch memory.
// Grants after WAIT_CYCLES wait states and answers one cycle after the grant edge.
module lint_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_WORDS   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1A10_0000,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    lint_slave_mem_if.slave   bus
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int IDX_W      = $clog2(NUM_WORDS);
    localparam int CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    r_valid_reg;
    logic                    r_opc_reg;
    logic [DATA_WIDTH-1:0]   rdata_all;

    logic [ADDR_WIDTH-1:0]   off;
    logic [IDX_W-1:0]        word_idx;
    logic                    in_range;
    logic                    gnt;
    logic                    wr_en;
    logic                    rd_en;
    logic                    unused_lsb;

    // Word index wraps inside the window; anything above it is flagged out of range.
    assign off        = bus.add - BASE_ADDR;
    assign word_idx   = off[BYTE_SHIFT +: IDX_W];
    assign in_range   = (bus.add >= BASE_ADDR) && (off[ADDR_WIDTH-1:BYTE_SHIFT+IDX_W] == '0);
    assign unused_lsb = ^off[BYTE_SHIFT-1:0];

    assign gnt   = bus.req && !rst_i &&
                   ((WAIT_CYCLES == 0) || ((state_reg == S_WAIT) && (cnt_reg == '0)));
    assign wr_en = gnt && !bus.wen && in_range;
    assign rd_en = in_range && bus.wen;

    assign bus.gnt     = gnt;
    assign bus.r_valid = r_valid_reg;
    assign bus.r_opc   = r_opc_reg;
    assign bus.r_rdata = rdata_all;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            r_valid_reg <= 1'b0;
            r_opc_reg   <= 1'b0;
        end else begin
            r_valid_reg <= gnt;
            if (gnt) begin
                r_opc_reg <= !in_range;
            end
            case (state_reg)
                S_IDLE: begin
                    if ((WAIT_CYCLES != 0) && bus.req) begin
                        state_reg <= S_WAIT;
                        cnt_reg   <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                S_WAIT: begin
                    // A dropped request abandons the transfer without any response.
                    if (!bus.req || (cnt_reg == '0)) begin
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // One narrow RAM per byte lane so byte enables map onto plain write enables.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [NUM_WORDS];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clk_i) begin
                if (wr_en && bus.be[gi]) begin
                    lane_mem[word_idx] <= bus.wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lane_rdata_reg <= 8'h00;
                end else if (gnt) begin
                    lane_rdata_reg <= rd_en ? lane_mem[word_idx] : 8'h00;
                end
            end

            assign rdata_all[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate
endmodule

// File: tb/tb_lint_slave_mem.sv
// Bench for lint_slave_mem: two instances (two wait states and zero wait states) checked
// against a reference memory model and a queue of expected responses.
module tb_lint_slave_mem;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          NW   = 256;
    localparam logic [31:0] BASE = 32'h1A10_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] m2 [NW];
    logic [31:0] m0 [NW];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lint_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
    lint_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    lint_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
                     .WAIT_CYCLES(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
    lint_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
                     .WAIT_CYCLES(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));

    function automatic logic in_rng(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && (o < NW * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return int'(o % NW);
    endfunction

    // Response monitors: pop the oldest expectation whenever r_valid shows up.
    always @(negedge clk) begin
        exp_t e;
        if (bus2.r_valid === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_spurious_rvalid: got r_valid=1 at cyc %0d, required none", cyc);
            end else begin
                e = q2.pop_front();
                if (cyc != e.cyc || bus2.r_rdata !== e.rdata || bus2.r_opc !== e.opc) begin
                    errors++;
                    $display("FAIL dut2_resp: got cyc=%0d rdata=%h opc=%b, required cyc=%0d rdata=%h opc=%b",
                             cyc, bus2.r_rdata, bus2.r_opc, e.cyc, e.rdata, e.opc);
                end else begin
                    $display("dut2 resp cyc=%0d rdata=%h opc=%b ok", cyc, bus2.r_rdata, bus2.r_opc);
                end
            end
        end else if (q2.size() > 0 && q2[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = q2.pop_front();
            $display("FAIL dut2_missing_rvalid: got r_valid=%b at cyc %0d, required 1", bus2.r_valid, cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus0.r_valid === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_spurious_rvalid: got r_valid=1 at cyc %0d, required none", cyc);
            end else begin
                e = q0.pop_front();
                if (cyc != e.cyc || bus0.r_rdata !== e.rdata || bus0.r_opc !== e.opc) begin
                    errors++;
                    $display("FAIL dut0_resp: got cyc=%0d rdata=%h opc=%b, required cyc=%0d rdata=%h opc=%b",
                             cyc, bus0.r_rdata, bus0.r_opc, e.cyc, e.rdata, e.opc);
                end else begin
                    $display("dut0 resp cyc=%0d rdata=%h opc=%b ok", cyc, bus0.r_rdata, bus0.r_opc);
                end
            end
        end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = q0.pop_front();
            $display("FAIL dut0_missing_rvalid: got r_valid=%b at cyc %0d, required 1", bus0.r_valid, cyc);
        end
    end

    // Issue one transfer on the two-wait-state DUT; returns at the negedge of the r_valid cycle
    // with req still asserted so the caller can chain the next request into that cycle.
    task automatic xfer2(input logic [31:0] a, input logic w_en, input logic [31:0] wd,
                         input logic [3:0] b, input string name);
        int   n;
        exp_t e;
        bus2.req = 1'b1; bus2.add = a; bus2.wen = w_en; bus2.wdata = wd; bus2.be = b;
        #1;
        n = 0;
        while (bus2.gnt !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s_wait: got gnt after %0d cycles, required 2", name, n);
        end
        if (bus2.gnt === 1'b1) begin
            e.cyc = cyc + 1; e.opc = !in_rng(a); e.rdata = 32'h0;
            if (in_rng(a)) begin
                if (w_en) e.rdata = m2[widx(a)];
                else for (int k = 0; k < 4; k++) if (b[k]) m2[widx(a)][k*8 +: 8] = wd[k*8 +: 8];
            end
            q2.push_back(e);
        end else begin
            bus2.req = 1'b0;
        end
        @(negedge clk);
    endtask

    // Zero-wait-state DUT: grant is expected in the same cycle as req.
    task automatic xfer0(input logic [31:0] a, input logic w_en, input logic [31:0] wd,
                         input logic [3:0] b, input string name);
        exp_t e;
        bus0.req = 1'b1; bus0.add = a; bus0.wen = w_en; bus0.wdata = wd; bus0.be = b;
        #1;
        checks++;
        if (bus0.gnt !== 1'b1) begin
            errors++;
            $display("FAIL %s_gnt: got gnt=%b, required 1", name, bus0.gnt);
            bus0.req = 1'b0;
        end else begin
            e.cyc = cyc + 1; e.opc = !in_rng(a); e.rdata = 32'h0;
            if (in_rng(a)) begin
                if (w_en) e.rdata = m0[widx(a)];
                else for (int k = 0; k < 4; k++) if (b[k]) m0[widx(a)][k*8 +: 8] = wd[k*8 +: 8];
            end
            q0.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus2.req = 1'b0;
        bus0.req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.req = 1'b1; bus2.add = BASE; bus2.wen = 1'b1; bus2.wdata = '0; bus2.be = 4'hF;
        bus0.req = 1'b1; bus0.add = BASE; bus0.wen = 1'b1; bus0.wdata = '0; bus0.be = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus2.gnt, bus2.r_valid, bus2.r_rdata, bus2.r_opc} !== 35'h0) begin
            errors++;
            $display("FAIL reset_dut2: got gnt=%b r_valid=%b rdata=%h opc=%b, required all 0",
                     bus2.gnt, bus2.r_valid, bus2.r_rdata, bus2.r_opc);
        end
        checks++;
        if ({bus0.gnt, bus0.r_valid, bus0.r_rdata, bus0.r_opc} !== 35'h0) begin
            errors++;
            $display("FAIL reset_dut0: got gnt=%b r_valid=%b rdata=%h opc=%b, required all 0",
                     bus0.gnt, bus0.r_valid, bus0.r_rdata, bus0.r_opc);
        end
        bus2.req = 1'b0; bus0.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        xfer2(BASE + 32'h10, 1'b0, 32'hDEADBEEF, 4'hF, "wr_full");
        xfer2(BASE + 32'h10, 1'b1, 32'h0, 4'h0, "rd_full");
        xfer2(BASE + 32'h10, 1'b0, 32'h11223344, 4'b0101, "wr_be");
        xfer2(BASE + 32'h10, 1'b1, 32'h0, 4'h0, "rd_be");
        xfer2(BASE + 32'h10, 1'b0, 32'hFFFFFFFF, 4'h0, "wr_be0");
        xfer2(BASE + 32'h10, 1'b1, 32'h0, 4'h0, "rd_be0");
        idle(2);
    endtask

    task automatic test_stream_zero_wait();
        for (int i = 0; i < 4; i++)
            xfer0(BASE + 32'(i * 4), 1'b0, $urandom, 4'hF, "s0_wr");
        for (int i = 0; i < 4; i++)
            xfer0(BASE + 32'(i * 4), 1'b1, 32'h0, 4'h0, "s0_rd");
        idle(2);
    endtask

    task automatic test_out_of_range();
        xfer2(BASE, 1'b0, 32'hA5A5A5A5, 4'hF, "oor_init0");
        xfer2(BASE + 32'h3FC, 1'b0, 32'h5A5A5A5A, 4'hF, "oor_initlast");
        xfer2(BASE + 32'h3FC, 1'b1, 32'h0, 4'h0, "oor_rdlast_pre");
        xfer2(BASE + 32'h400, 1'b1, 32'h0, 4'h0, "oor_rd_hi");
        xfer2(BASE - 32'h4, 1'b1, 32'h0, 4'h0, "oor_rd_lo");
        xfer2(BASE + 32'h400, 1'b0, 32'hFFFFFFFF, 4'hF, "oor_wr_hi");
        xfer2(BASE - 32'h4, 1'b0, 32'hFFFFFFFF, 4'hF, "oor_wr_lo");
        xfer2(BASE, 1'b1, 32'h0, 4'h0, "oor_rd0");
        xfer2(BASE + 32'h3FC, 1'b1, 32'h0, 4'h0, "oor_rdlast");
        idle(2);
    endtask

    task automatic test_reset_abort();
        xfer2(BASE + 32'h20, 1'b0, 32'hCAFEF00D, 4'hF, "ra_wr");
        xfer2(BASE + 32'h20, 1'b1, 32'h0, 4'h0, "ra_rd");
        idle(2);
        bus2.req = 1'b1; bus2.add = BASE + 32'h20; bus2.wen = 1'b0;
        bus2.wdata = 32'h0BADBEEF; bus2.be = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus2.gnt, bus2.r_valid, bus2.r_rdata, bus2.r_opc} !== 35'h0) begin
            errors++;
            $display("FAIL reset_abort: got gnt=%b r_valid=%b rdata=%h opc=%b, required all 0",
                     bus2.gnt, bus2.r_valid, bus2.r_rdata, bus2.r_opc);
        end
        bus2.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        xfer2(BASE + 32'h20, 1'b1, 32'h0, 4'h0, "ra_readback");
        idle(2);
    endtask

    task automatic test_req_drop();
        bus2.req = 1'b1; bus2.add = BASE + 32'h30; bus2.wen = 1'b0;
        bus2.wdata = 32'h55555555; bus2.be = 4'hF;
        @(negedge clk);
        bus2.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus2.gnt !== 1'b0) begin
                errors++;
                $display("FAIL req_drop_gnt: got gnt=%b in cycle %0d after drop, required 0", bus2.gnt, i);
            end
            @(negedge clk);
        end
        xfer2(BASE + 32'h30, 1'b0, 32'h12345678, 4'hF, "rd_after_drop_wr");
        xfer2(BASE + 32'h30, 1'b1, 32'h0, 4'h0, "rd_after_drop_rd");
        idle(2);
    endtask

    task automatic test_back_to_back();
        xfer2(BASE + 32'h40, 1'b0, 32'h0F0F1234, 4'hF, "b2b_wr");
        xfer2(BASE + 32'h40, 1'b1, 32'h0, 4'h0, "b2b_rd");
        xfer2(BASE + 32'h44, 1'b0, 32'h89ABCDEF, 4'b1100, "b2b_wr2");
        xfer2(BASE + 32'h44, 1'b1, 32'h0, 4'h0, "b2b_rd2");
        idle(1);
        xfer0(BASE + 32'h80, 1'b0, 32'h600DF00D, 4'hF, "raw_wr");
        xfer0(BASE + 32'h80, 1'b1, 32'h0, 4'h0, "raw_rd");
        xfer0(BASE + 32'h400, 1'b1, 32'h0, 4'h0, "raw_oor");
        xfer0(BASE + 32'h80, 1'b1, 32'h0, 4'h0, "raw_rd2");
        idle(3);
    endtask

    initial begin
        rst = 1'b1;
        bus2.req = 1'b0; bus2.add = '0; bus2.wen = 1'b1; bus2.wdata = '0; bus2.be = '0;
        bus0.req = 1'b0; bus0.add = '0; bus0.wen = 1'b1; bus0.wdata = '0; bus0.be = '0;
        test_reset();
        test_write_read();
        test_stream_zero_wait();
        test_out_of_range();
        test_reset_abort();
        test_req_drop();
        test_back_to_back();
        idle(3);
        checks++;
        if (q2.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding, required 0/0", q2.size(), q0.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
